// File: rtl/control_reloj_if.sv
// control_reloj_if: button/tick inputs and time/mode outputs of the clock
// controller.
//   tick_min, btnModo, btnHora, btnMin : one-cycle pulses into the controller
//   alarmaEn                           : alarm armed level
//   modo, minutos, horas               : current mode and time
//   minutosAl, horasAl                 : alarm time
//   alarma                             : buzzer drive
// The slave modport is used by the controller; master is the driving side.
interface control_reloj_if;
  logic       tick_min;
  logic       btnModo;
  logic       btnHora;
  logic       btnMin;
  logic       alarmaEn;
  logic [1:0] modo;
  logic [6:0] minutos;
  logic [4:0] horas;
  logic [6:0] minutosAl;
  logic [4:0] horasAl;
  logic       alarma;

  modport master (
    output tick_min, btnModo, btnHora, btnMin, alarmaEn,
    input  modo, minutos, horas, minutosAl, horasAl, alarma
  );

  modport slave (
    input  tick_min, btnModo, btnHora, btnMin, alarmaEn,
    output modo, minutos, horas, minutosAl, horasAl, alarma
  );
endinterface

// File: rtl/control_reloj.sv
// control_reloj: mode and timekeeping controller for the digital clock.
// Keeps the current time and alarm time, advances time on tick_min, sequences
// NORMAL / AJUSTE_HORA / AJUSTE_ALARMA / ALARMA from debounced buttons and
// drives the buzzer.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : control_reloj_if.slave (button/tick inputs, mode/time outputs)
module control_reloj #(
  parameter int unsigned HORA_AL_INI = 6,
  parameter int unsigned MIN_AL_INI  = 0,
  parameter int unsigned DURACION_AL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  control_reloj_if.slave   bus
);

  typedef enum logic [1:0] {
    NORMAL        = 2'd0,
    AJUSTE_HORA   = 2'd1,
    AJUSTE_ALARMA = 2'd2,
    ALARMA        = 2'd3
  } estado_t;

  localparam logic [3:0] DUR = 4'(DURACION_AL);

  estado_t    estado, estado_n;
  logic [6:0] minutos, minutos_n, minutosAl, minutosAl_n, min_adv;
  logic [4:0] horas, horas_n, horasAl, horasAl_n, hor_adv;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic       alarma;
  logic       avanza, coincide, boton;

  function automatic logic [6:0] inc60(input logic [6:0] v);
    return (v >= 7'd59) ? '0 : v + 7'd1;
  endfunction

  function automatic logic [4:0] inc24(input logic [4:0] v);
    return (v >= 5'd23) ? '0 : v + 5'd1;
  endfunction

  always_comb begin
    avanza   = bus.tick_min && (estado != AJUSTE_HORA);
    min_adv  = minutos;
    hor_adv  = horas;
    if (avanza) begin
      min_adv = inc60(minutos);
      if (minutos == 7'd59) hor_adv = inc24(horas);
    end
    // Match is evaluated on the freshly advanced time so ALARMA is entered
    // on the same edge that loads the matching time.
    coincide = avanza && bus.alarmaEn &&
               (min_adv == minutosAl) && (hor_adv == horasAl);
    boton    = bus.btnModo || bus.btnHora || bus.btnMin;
    cnt_inc  = cnt + 4'd1;

    estado_n    = estado;
    minutos_n   = min_adv;
    horas_n     = hor_adv;
    minutosAl_n = minutosAl;
    horasAl_n   = horasAl;
    cnt_n       = '0;

    unique case (estado)
      NORMAL: begin
        if (coincide)         estado_n = ALARMA;
        else if (bus.btnModo) estado_n = AJUSTE_HORA;
      end
      AJUSTE_HORA: begin
        if (bus.btnModo) estado_n = AJUSTE_ALARMA;
        else begin
          if (bus.btnHora) horas_n   = inc24(horas);
          if (bus.btnMin)  minutos_n = inc60(minutos);
        end
      end
      AJUSTE_ALARMA: begin
        if (bus.btnModo) estado_n = NORMAL;
        else begin
          if (bus.btnHora) horasAl_n   = inc24(horasAl);
          if (bus.btnMin)  minutosAl_n = inc60(minutosAl);
        end
      end
      ALARMA: begin
        if (boton || !bus.alarmaEn) estado_n = NORMAL;
        else if (bus.tick_min) begin
          if (cnt_inc == DUR) estado_n = NORMAL;
          else                cnt_n    = cnt_inc;
        end else cnt_n = cnt;
      end
      default: estado_n = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= NORMAL;
      minutos   <= '0;
      horas     <= '0;
      minutosAl <= 7'(MIN_AL_INI);
      horasAl   <= 5'(HORA_AL_INI);
      cnt       <= '0;
      alarma    <= 1'b0;
    end else begin
      estado    <= estado_n;
      minutos   <= minutos_n;
      horas     <= horas_n;
      minutosAl <= minutosAl_n;
      horasAl   <= horasAl_n;
      cnt       <= cnt_n;
      alarma    <= (estado_n == ALARMA);
    end
  end

  assign bus.modo      = estado;
  assign bus.minutos   = minutos;
  assign bus.horas     = horas;
  assign bus.minutosAl = minutosAl;
  assign bus.horasAl   = horasAl;
  assign bus.alarma    = alarma;

endmodule

// File: tb/tb_control_reloj.sv
// tb_control_reloj: directed scenarios plus randomized pulses for
// control_reloj, checked every cycle against a minutes-of-day model.
module tb_control_reloj;

  localparam int AL_H = 6;
  localparam int AL_M = 0;
  localparam int DUR  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   clk_en = 1'b1;
  bit   en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: time and alarm as minutes since midnight.
  int m_t, m_al, m_mode, m_ring;

  control_reloj_if bus ();

  control_reloj #(
    .HORA_AL_INI (AL_H),
    .MIN_AL_INI  (AL_M),
    .DURACION_AL (DUR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".modo"},      int'(bus.modo),      m_mode);
    check({tag, ".horas"},     int'(bus.horas),     m_t / 60);
    check({tag, ".minutos"},   int'(bus.minutos),   m_t % 60);
    check({tag, ".horasAl"},   int'(bus.horasAl),   m_al / 60);
    check({tag, ".minutosAl"}, int'(bus.minutosAl), m_al % 60);
    check({tag, ".alarma"},    int'(bus.alarma),    (m_mode == 3) ? 1 : 0);
  endtask

  function automatic int hora_mas(input int t);
    return ((t / 60 + 1) % 24) * 60 + t % 60;
  endfunction

  function automatic int min_mas(input int t);
    return (t / 60) * 60 + (t % 60 + 1) % 60;
  endfunction

  task automatic model_reset();
    m_t = 0; m_al = AL_H * 60 + AL_M; m_mode = 0; m_ring = 0;
  endtask

  task automatic model_step(input bit tk, bm, bh, bmi, ena);
    int nt, nm;
    bit adv;
    adv = tk && (m_mode != 1);
    nt  = adv ? (m_t + 1) % 1440 : m_t;
    nm  = m_mode;
    case (m_mode)
      0: if (adv && ena && nt == m_al) nm = 3;
         else if (bm) nm = 1;
      1: if (bm) nm = 2;
         else begin
           if (bh)  nt = hora_mas(nt);
           if (bmi) nt = min_mas(nt);
         end
      2: if (bm) nm = 0;
         else begin
           if (bh)  m_al = hora_mas(m_al);
           if (bmi) m_al = min_mas(m_al);
         end
      default: if (bm || bh || bmi || !ena) nm = 0;
         else if (tk) begin
           m_ring++;
           if (m_ring == DUR) nm = 0;
         end
    endcase
    if (nm != 3) m_ring = 0;
    m_t = nt;
    m_mode = nm;
  endtask

  // Called just after a falling edge; applies one cycle of inputs.
  task automatic step(input bit tk, bm, bh, bmi);
    bus.tick_min = tk; bus.btnModo = bm; bus.btnHora = bh; bus.btnMin = bmi;
    bus.alarmaEn = en;
    @(posedge clk);
    model_step(tk, bm, bh, bmi, en);
    @(negedge clk);
    bus.tick_min = 0; bus.btnModo = 0; bus.btnHora = 0; bus.btnMin = 0;
    check_all("step");
  endtask

  // From NORMAL: set the time through AJUSTE_HORA, then cycle back to NORMAL.
  task automatic goto_time(input int h, input int m);
    step(0, 1, 0, 0);
    for (int i = 0; i < 24 && (m_t / 60) != h; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 60 && (m_t % 60) != m; i++) step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
  endtask

  task automatic do_reset();
    bus.tick_min = 0; bus.btnModo = 0; bus.btnHora = 0; bus.btnMin = 0;
    bus.alarmaEn = en;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    en = 0;
    do_reset();
    check("reset.horasAl", int'(bus.horasAl), 6);

    // 61 minutes of running time.
    repeat (61) step(1, 0, 0, 0);
    check("run.horas", int'(bus.horas), 1);
    check("run.minutos", int'(bus.minutos), 1);
    check("run.modo", int'(bus.modo), 0);

    // 23:59 -> 00:00.
    goto_time(23, 59);
    step(1, 0, 0, 0);
    check("wrap.horas", int'(bus.horas), 0);
    check("wrap.minutos", int'(bus.minutos), 0);

    // btnMin at 59 in AJUSTE_HORA wraps without carry.
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("minwrap.horas", int'(bus.horas), 1);
    check("minwrap.minutos", int'(bus.minutos), 0);
    // btnModo with btnHora: mode change wins.
    step(0, 1, 1, 0);
    check("prio.modo", int'(bus.modo), 2);
    check("prio.horas", int'(bus.horas), 1);
    step(0, 1, 0, 0);
    check("cycle.modo", int'(bus.modo), 0);

    // Alarm trigger and ring end.
    en = 1;
    goto_time(5, 59);
    step(1, 0, 0, 0);
    check("trig.modo", int'(bus.modo), 3);
    check("trig.alarma", int'(bus.alarma), 1);
    step(1, 0, 0, 0);
    check("ringend.modo", int'(bus.modo), 0);
    check("ringend.minutos", int'(bus.minutos), 1);

    // Dismiss by btnHora makes no edit.
    goto_time(5, 59);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("dismiss.modo", int'(bus.modo), 0);
    check("dismiss.horas", int'(bus.horas), 6);

    // alarmaEn low: no trigger.
    en = 0;
    goto_time(5, 59);
    step(1, 0, 0, 0);
    check("noarm.modo", int'(bus.modo), 0);

    // Match inside AJUSTE_ALARMA never rings.
    en = 1;
    goto_time(5, 59);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    check("ajal.modo", int'(bus.modo), 2);
    check("ajal.minutos", int'(bus.minutos), 0);
    step(0, 1, 0, 0);

    // alarmaEn dropping ends the ring.
    goto_time(5, 59);
    step(1, 0, 0, 0);
    en = 0;
    step(0, 0, 0, 0);
    check("disarm.modo", int'(bus.modo), 0);
    en = 1;

    // Randomized pulses.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(63) == 0) en = ~en;
      step($urandom_range(2) == 0, $urandom_range(7) == 0,
           $urandom_range(3) == 0, $urandom_range(3) == 0);
    end

    // Asynchronous reset while ringing with the clock stopped.
    do_reset();
    en = 1;
    goto_time(5, 59);
    step(1, 0, 0, 0);
    check("pre_rst.alarma", int'(bus.alarma), 1);
    clk_en = 0;
    #20;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.horasAl", int'(bus.horasAl), 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
